// File: rtl/minmax_stream.sv
// Streaming min/max finder: takes NI samples one beat at a time and reports the
// extreme value and its lowest index over a valid/ready output.
module minmax_stream #(
  parameter int W    = 5,
  parameter int NI   = 9,
  parameter int IDXW = $clog2(NI)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            us_sel,
  input  logic            min_max_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    result,
  output logic [IDXW-1:0] index
);

  typedef enum logic {ACC, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_cnt;
  logic [W-1:0]    r_best;
  logic [IDXW-1:0] r_best_idx;
  logic            r_us, r_mm;
  logic [W-1:0]    r_result;
  logic [IDXW-1:0] r_index;

  logic            w_accept, w_first, w_last, w_lt, w_gt, w_take;
  logic [W-1:0]    w_best_nxt;
  logic [IDXW-1:0] w_idx_nxt;

  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == IDXW'(NI - 1));

  // Strict compares under the latched mode, so ties keep the earlier sample.
  assign w_lt   = r_us ? ($signed(in_data) < $signed(r_best)) : (in_data < r_best);
  assign w_gt   = r_us ? ($signed(in_data) > $signed(r_best)) : (in_data > r_best);
  assign w_take = w_first || (r_mm ? w_gt : w_lt);

  assign w_best_nxt = w_take ? in_data : r_best;
  assign w_idx_nxt  = w_take ? r_cnt   : r_best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ACC;
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_us       <= 1'b0;
      r_mm       <= 1'b0;
      r_result   <= '0;
      r_index    <= '0;
    end else if (w_accept) begin
      r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
      r_best     <= w_best_nxt;
      r_best_idx <= w_idx_nxt;
      if (w_first) begin
        r_us <= us_sel;
        r_mm <= min_max_sel;
      end
      if (w_last) begin
        r_result <= w_best_nxt;
        r_index  <= w_idx_nxt;
      end
    end
  end

  assign result = r_result;
  assign index  = r_index;

endmodule
